imem_loader_ctrl: RTL and testbench

Controller that sequences the instruction-fetch stage's instruction memory and run control. It consumes a byte stream from the debug UART receiver, decodes one-byte commands, and performs the following:
- assembles 32-bit instruction words and writes them into instruction memory via the fetch stage's write-enable/address/data inputs;
- holds the pipeline in reset during loading;
- releases the pipeline in continuous or single-step mode via the fetch-stage halt input.

---
 rtl/imem_loader_ctrl.sv | 248 ++++++++++++++++++++++++
 tb/tb_imem_loader_ctrl.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader_ctrl.sv
// imem_loader_ctrl: decodes one-byte debug-UART commands, loads 32-bit words
// into the fetch stage's instruction memory and gates the pipeline's run control.
module imem_loader_ctrl #(
    parameter int unsigned ADDR_INC = 4,
    parameter int unsigned NB_ADDR  = 32
) (
    input  logic               clk,
    input  logic               i_rst,
    input  logic [7:0]         i_rx_data,
    input  logic               i_rx_valid,
    output logic               o_rx_ready,
    input  logic               i_prog_halted,
    output logic               o_we,
    output logic [NB_ADDR-1:0] o_inst_addr,
    output logic [31:0]        o_instr_data,
    output logic               o_halt,
    output logic               o_pipe_rst_n,
    output logic               o_busy,
    output logic               o_load_done
);

    localparam int unsigned NB_DATA = 32;
    localparam int unsigned NB_BYTE = 8;
    localparam int unsigned NB_CNT  = 9;
    localparam int unsigned NB_IDX  = 2;

    localparam logic [NB_BYTE-1:0] CMD_LOAD = 8'h4C;
    localparam logic [NB_BYTE-1:0] CMD_RUN  = 8'h52;
    localparam logic [NB_BYTE-1:0] CMD_STEP = 8'h53;
    localparam logic [NB_BYTE-1:0] CMD_STOP = 8'h48;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_GET_CNT  = 3'd1,
        ST_GET_BYTE = 3'd2,
        ST_WRITE    = 3'd3,
        ST_DONE     = 3'd4,
        ST_RUN      = 3'd5,
        ST_STEP     = 3'd6
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Registered copies of the state-decoded outputs
    logic r_rx_ready;
    logic r_we;
    logic r_halt;
    logic r_pipe_rst_n;
    logic r_busy;
    logic r_load_done;

    logic w_rx_ready_next;
    logic w_we_next;
    logic w_halt_next;
    logic w_pipe_rst_n_next;
    logic w_busy_next;
    logic w_load_done_next;

    // Load datapath
    logic [NB_ADDR-1:0] r_addr;
    logic [NB_DATA-1:0] r_word;
    logic [NB_CNT-1:0]  r_words_left;
    logic [NB_IDX-1:0]  r_byte_idx;
    logic [NB_ADDR-1:0] r_inst_addr;
    logic [NB_DATA-1:0] r_instr_data;

    logic               w_accept;
    logic               w_last_byte;
    logic [NB_CNT-1:0]  w_count_load;
    logic [NB_DATA-1:0] w_word_full;

    assign w_accept     = i_rx_valid && r_rx_ready;
    assign w_last_byte  = (r_byte_idx == NB_IDX'(3));
    // A count byte of zero stands for a full 256-word image
    assign w_count_load = (i_rx_data == 8'h00) ? NB_CNT'(256) : NB_CNT'(i_rx_data);
    // Completed little-endian word: the fourth byte fills the top lane
    assign w_word_full  = {i_rx_data, r_word[23:0]};

    // Next-state and next-output decode
    always_comb begin
        w_state_next      = r_state;
        w_rx_ready_next   = 1'b1;
        w_we_next         = 1'b0;
        w_halt_next       = 1'b1;
        w_pipe_rst_n_next = 1'b1;
        w_load_done_next  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    case (i_rx_data)
                        CMD_LOAD: w_state_next = ST_GET_CNT;
                        CMD_RUN:  w_state_next = ST_RUN;
                        CMD_STEP: w_state_next = ST_STEP;
                        default:  w_state_next = ST_IDLE;
                    endcase
                end
            end
            ST_GET_CNT: begin
                if (w_accept) begin
                    w_state_next = ST_GET_BYTE;
                end
            end
            ST_GET_BYTE: begin
                if (w_accept && w_last_byte) begin
                    w_state_next = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (r_words_left == NB_CNT'(1)) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_state_next = ST_GET_BYTE;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            ST_RUN: begin
                if (i_prog_halted || (w_accept && (i_rx_data == CMD_STOP))) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_STEP: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        w_busy_next = (w_state_next != ST_IDLE);

        case (w_state_next)
            ST_GET_CNT, ST_GET_BYTE: begin
                w_pipe_rst_n_next = 1'b0;
            end
            ST_WRITE: begin
                w_rx_ready_next   = 1'b0;
                w_we_next         = 1'b1;
                w_pipe_rst_n_next = 1'b0;
            end
            ST_DONE: begin
                w_rx_ready_next   = 1'b0;
                w_load_done_next  = 1'b1;
                w_pipe_rst_n_next = 1'b0;
            end
            ST_RUN: begin
                w_halt_next = 1'b0;
            end
            ST_STEP: begin
                w_halt_next     = 1'b0;
                w_rx_ready_next = 1'b0;
            end
            default: begin
                w_halt_next = 1'b1;
            end
        endcase
    end

    // State and control-output registers
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_rx_ready   <= 1'b1;
            r_we         <= 1'b0;
            r_halt       <= 1'b1;
            r_pipe_rst_n <= 1'b1;
            r_busy       <= 1'b0;
            r_load_done  <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_rx_ready   <= w_rx_ready_next;
            r_we         <= w_we_next;
            r_halt       <= w_halt_next;
            r_pipe_rst_n <= w_pipe_rst_n_next;
            r_busy       <= w_busy_next;
            r_load_done  <= w_load_done_next;
        end
    end

    // Word count, byte lane index and running write address
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            r_addr       <= '0;
            r_words_left <= '0;
            r_byte_idx   <= '0;
        end else begin
            case (r_state)
                ST_GET_CNT: begin
                    if (w_accept) begin
                        r_words_left <= w_count_load;
                        r_addr       <= '0;
                        r_byte_idx   <= '0;
                    end
                end
                ST_GET_BYTE: begin
                    if (w_accept) begin
                        r_byte_idx <= r_byte_idx + NB_IDX'(1);
                    end
                end
                ST_WRITE: begin
                    r_addr       <= r_addr + NB_ADDR'(ADDR_INC);
                    r_words_left <= r_words_left - NB_CNT'(1);
                end
                default: begin
                    r_words_left <= r_words_left;
                end
            endcase
        end
    end

    // Little-endian byte assembly of the word in progress
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            r_word <= '0;
        end else if ((r_state == ST_GET_BYTE) && w_accept) begin
            case (r_byte_idx)
                2'd0:    r_word[7:0]   <= i_rx_data;
                2'd1:    r_word[15:8]  <= i_rx_data;
                2'd2:    r_word[23:16] <= i_rx_data;
                default: r_word[31:24] <= i_rx_data;
            endcase
        end
    end

    // Write port registers: captured as WRITE is entered, held afterwards
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            r_inst_addr  <= '0;
            r_instr_data <= '0;
        end else if (w_state_next == ST_WRITE) begin
            r_inst_addr  <= r_addr;
            r_instr_data <= w_word_full;
        end
    end

    assign o_rx_ready   = r_rx_ready;
    assign o_we         = r_we;
    assign o_inst_addr  = r_inst_addr;
    assign o_instr_data = r_instr_data;
    assign o_halt       = r_halt;
    assign o_pipe_rst_n = r_pipe_rst_n;
    assign o_busy       = r_busy;
    assign o_load_done  = r_load_done;

endmodule

// File: tb/tb_imem_loader_ctrl.sv
// tb_imem_loader_ctrl: randomized command/byte stimulus for imem_loader_ctrl,
// checked against expectations derived from the command rules and cycle budgets.
module tb_imem_loader_ctrl;

    localparam int unsigned ADDR_INC = 4;
    localparam int unsigned NB_ADDR  = 32;

    logic               clk = 1'b0;
    logic               i_rst = 1'b0;
    logic [7:0]         i_rx_data = 8'h00;
    logic               i_rx_valid = 1'b0;
    logic               o_rx_ready;
    logic               i_prog_halted = 1'b0;
    logic               o_we;
    logic [NB_ADDR-1:0] o_inst_addr;
    logic [31:0]        o_instr_data;
    logic               o_halt;
    logic               o_pipe_rst_n;
    logic               o_busy;
    logic               o_load_done;

    imem_loader_ctrl #(.ADDR_INC(ADDR_INC), .NB_ADDR(NB_ADDR)) dut (
        .clk          (clk),
        .i_rst        (i_rst),
        .i_rx_data    (i_rx_data),
        .i_rx_valid   (i_rx_valid),
        .o_rx_ready   (o_rx_ready),
        .i_prog_halted(i_prog_halted),
        .o_we         (o_we),
        .o_inst_addr  (o_inst_addr),
        .o_instr_data (o_instr_data),
        .o_halt       (o_halt),
        .o_pipe_rst_n (o_pipe_rst_n),
        .o_busy       (o_busy),
        .o_load_done  (o_load_done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int last_acc_cyc = 0;

    // Observation counters and write log, sampled mid-cycle
    int we_cnt = 0;
    int done_cnt = 0;
    int last_done_cyc = 0;
    int pipe_low_cnt = 0;
    int rx_low_cnt = 0;
    int halt_low_cnt = 0;
    logic [31:0] q_addr[$];
    logic [31:0] q_data[$];
    int          q_cyc[$];
    logic [7:0]  load_bytes[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (o_we) begin
            we_cnt++;
            q_addr.push_back(o_inst_addr);
            q_data.push_back(o_instr_data);
            q_cyc.push_back(cyc);
        end
        if (o_load_done) begin
            done_cnt++;
            last_done_cyc = cyc;
        end
        if (!o_pipe_rst_n) pipe_low_cnt++;
        if (!o_rx_ready) rx_low_cnt++;
        if (!o_halt) halt_low_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Present a byte until the controller takes it (bounded)
    task automatic send_byte(input logic [7:0] b);
        bit acc = 1'b0;
        for (int n = 0; n < 50 && !acc; n++) begin
            @(negedge clk);
            i_rx_valid = 1'b1;
            i_rx_data  = b;
            acc = o_rx_ready;
            @(posedge clk);
            #1;
            i_rx_valid = 1'b0;
        end
        last_acc_cyc = cyc;
        if (!acc) check("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_halt"},   64'(o_halt), 64'd1);
        check({tag, "_prstn"},  64'(o_pipe_rst_n), 64'd1);
        check({tag, "_we"},     64'(o_we), 64'd0);
        check({tag, "_done"},   64'(o_load_done), 64'd0);
        check({tag, "_busy"},   64'(o_busy), 64'd0);
        check({tag, "_ready"},  64'(o_rx_ready), 64'd1);
        check({tag, "_addr"},   64'(o_inst_addr), 64'd0);
        check({tag, "_data"},   64'(o_instr_data), 64'd0);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_halt"},  64'(o_halt), 64'd1);
        check({tag, "_busy"},  64'(o_busy), 64'd0);
        check({tag, "_ready"}, 64'(o_rx_ready), 64'd1);
        check({tag, "_prstn"}, 64'(o_pipe_rst_n), 64'd1);
    endtask

    // Load n words from load_bytes with bytes streamed back-to-back
    task automatic do_load(input int n);
        int we0, dn0, pl0, rl0, t_l, nw;
        logic [31:0] exp_w;
        we0 = we_cnt; dn0 = done_cnt; pl0 = pipe_low_cnt; rl0 = rx_low_cnt;
        q_addr.delete(); q_data.delete(); q_cyc.delete();
        send_byte(8'h4C);
        t_l = last_acc_cyc;
        send_byte(8'(n));
        for (int i = 0; i < 4 * n; i++) send_byte(load_bytes[i]);
        for (int k = 0; k < 10 && done_cnt == dn0; k++) begin
            @(negedge clk);
            #1;
        end
        check("ld_done_pulses", 64'(done_cnt - dn0), 64'd1);
        check("ld_done_cycle",  64'(last_done_cyc - t_l), 64'(5 * n + 1));
        check("ld_we_pulses",   64'(we_cnt - we0), 64'(n));
        check("ld_prstn_low",   64'(pipe_low_cnt - pl0), 64'(5 * n + 2));
        check("ld_ready_low",   64'(rx_low_cnt - rl0), 64'(n + 1));
        nw = (q_addr.size() < n) ? q_addr.size() : n;
        for (int i = 0; i < nw; i++) begin
            exp_w = {load_bytes[4*i+3], load_bytes[4*i+2], load_bytes[4*i+1], load_bytes[4*i]};
            check("wr_addr", 64'(q_addr[i]), 64'(32'(i * ADDR_INC)));
            check("wr_data", 64'(q_data[i]), 64'(exp_w));
            check("wr_cycle", 64'(q_cyc[i] - t_l), 64'(5 * i + 5));
        end
        @(negedge clk);
        #1;
        check_idle("ld_after");
    endtask

    task automatic fill_random(input int n);
        load_bytes.delete();
        for (int i = 0; i < 4 * n; i++) load_bytes.push_back(8'($urandom));
    endtask

    // mode 0: i_prog_halted, 1: 'H' byte, 2: both in one cycle
    task automatic do_run(input int mode, input int wait_cyc);
        send_byte(8'h52);
        repeat (wait_cyc) @(negedge clk);
        #1;
        check("run_halt_low", 64'(o_halt), 64'd0);
        check("run_busy", 64'(o_busy), 64'd1);
        if (mode == 1) begin
            send_byte(8'h48);
        end else begin
            @(negedge clk);
            i_prog_halted = 1'b1;
            if (mode == 2) begin
                i_rx_valid = 1'b1;
                i_rx_data  = 8'h48;
            end
            @(posedge clk);
            #1;
            i_prog_halted = 1'b0;
            i_rx_valid    = 1'b0;
        end
        @(negedge clk);
        #1;
        check_idle("run_exit");
        @(negedge clk);
        #1;
        check("run_exit_stays", 64'(o_busy), 64'd0);
    endtask

    task automatic do_step();
        int h0;
        h0 = halt_low_cnt;
        send_byte(8'h53);
        @(negedge clk);
        #1;
        check("step_halt", 64'(o_halt), 64'd0);
        check("step_ready", 64'(o_rx_ready), 64'd0);
        @(negedge clk);
        #1;
        check_idle("step_after");
        repeat (3) @(negedge clk);
        #1;
        check("step_halt_cycles", 64'(halt_low_cnt - h0), 64'd1);
    endtask

    task automatic do_stray(input logic [7:0] b);
        int we0, pl0, h0;
        we0 = we_cnt; pl0 = pipe_low_cnt; h0 = halt_low_cnt;
        send_byte(b);
        repeat (2) @(negedge clk);
        #1;
        check_idle("stray");
        check("stray_we", 64'(we_cnt - we0), 64'd0);
        check("stray_prstn", 64'(pipe_low_cnt - pl0), 64'd0);
        check("stray_halt", 64'(halt_low_cnt - h0), 64'd0);
    endtask

    initial begin
        logic [7:0] b;
        // Reset at start, values held across clock edges
        #1 i_rst = 1'b1;
        #2;
        check_reset_vals("rst0");
        repeat (3) @(negedge clk);
        check_reset_vals("rst0_hold");
        i_rst = 1'b0;
        @(negedge clk);

        // Single known word
        load_bytes.delete();
        load_bytes.push_back(8'h13); load_bytes.push_back(8'h00);
        load_bytes.push_back(8'h10); load_bytes.push_back(8'h00);
        do_load(1);
        check("w1_data_hold", 64'(o_instr_data), 64'h0010_0013);
        check("w1_addr_hold", 64'(o_inst_addr), 64'd0);

        // Three words
        fill_random(3);
        do_load(3);
        check("w3_addr_hold", 64'(o_inst_addr), 64'd8);

        // Run exits: prog_halted, 'H', both together
        do_run(0, 20);
        do_run(1, 20);
        do_run(2, 20);

        // Step and stray bytes
        do_step();
        do_stray(8'h00);
        do_stray(8'hFF);
        do_stray(8'h48);

        // Stray 'L' while running is discarded
        send_byte(8'h52);
        send_byte(8'h4C);
        @(negedge clk);
        #1;
        check("run_stray_halt", 64'(o_halt), 64'd0);
        check("run_stray_prstn", 64'(o_pipe_rst_n), 64'd1);
        send_byte(8'h48);
        @(negedge clk);
        #1;
        check_idle("run_stray_exit");

        // i_prog_halted outside RUN has no effect
        @(negedge clk);
        i_prog_halted = 1'b1;
        repeat (2) @(negedge clk);
        i_prog_halted = 1'b0;
        #1;
        check_idle("idle_prog_halted");

        // Randomized operation mix
        for (int it = 0; it < 12; it++) begin
            case ($urandom_range(0, 4))
                0: begin
                    int n;
                    n = int'($urandom_range(1, 6));
                    fill_random(n);
                    do_load(n);
                end
                1: do_run(0, int'($urandom_range(1, 15)));
                2: do_run(int'($urandom_range(1, 2)), int'($urandom_range(1, 15)));
                3: do_step();
                default: begin
                    b = 8'($urandom);
                    while (b == 8'h4C || b == 8'h52 || b == 8'h53) b = 8'($urandom);
                    do_stray(b);
                end
            endcase
        end

        // Full 256-word image (count byte 0x00)
        fill_random(256);
        do_load(256);
        check("w256_addr_hold", 64'(o_inst_addr), 64'h3FC);

        // Reset in the middle of a load
        send_byte(8'h4C);
        send_byte(8'h02);
        send_byte(8'hAA);
        send_byte(8'h55);
        @(negedge clk);
        #1;
        check("midld_prstn_low", 64'(o_pipe_rst_n), 64'd0);
        i_rst = 1'b1;
        #1;
        check_reset_vals("midld_rst");
        repeat (2) @(negedge clk);
        #1;
        check_reset_vals("midld_rst_hold");
        @(negedge clk);
        i_rst = 1'b0;
        do_step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global guard against a stalled run
    initial begin
        #2000000;
        $display("FAIL global_timeout: got=stalled expected=finish");
        $fatal(1);
    end

endmodule
